// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel integer clock divider.
package clk_div_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } div_state_t;

    localparam int MIN_DIV = 2;
endpackage

// File: rtl/clk_div_core.sv
// One divider channel: phase FSM, phase counter, shadow ratio and glitch-free bypass mux.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         ref_clk,
    input  logic         rst_n,
    input  logic         div_en,
    input  logic [W-1:0] div_ratio,
    output logic         div_clk,
    output logic         div_tick,
    output logic [W-1:0] ratio_act
);
    localparam logic [W-1:0] MIN_W = W'(MIN_DIV);

    div_state_t   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] ratio_q, ratio_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic         bypass_sel;
    logic [W-1:0] half_hi, half_lo;
    logic         start_ok;

    // Odd ratios put the extra cycle in the low phase.
    assign half_hi  = ratio_q >> 1;
    assign half_lo  = ratio_q - half_hi;
    assign start_ok = div_en && (div_ratio >= MIN_W);

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ratio_q <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                ratio_d = div_ratio;
                cnt_d   = '0;
                clk_d   = 1'b0;
                if (start_ok) begin
                    state_d = HIGH;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end
            HIGH: begin
                clk_d = 1'b1;
                if (cnt_q == half_hi - 1'b1) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                clk_d = 1'b0;
                if (cnt_q == half_lo - 1'b1) begin
                    // Period boundary: the only point where enable and ratio are honoured.
                    cnt_d = '0;
                    if (start_ok) begin
                        ratio_d = div_ratio;
                        state_d = HIGH;
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    // Select changes only while ref_clk is low, so the mux cannot produce a runt pulse.
    always_ff @(negedge ref_clk or negedge rst_n) begin
        if (!rst_n) bypass_sel <= 1'b0;
        else        bypass_sel <= (state_q == IDLE) && div_en && (ratio_q < MIN_W);
    end

    assign div_clk   = bypass_sel ? ref_clk : clk_q;
    assign div_tick  = tick_q;
    assign ratio_act = ratio_q;
endmodule

// File: rtl/clk_div_multi_ch.sv
// NUM_CH independent integer clock dividers sharing one reference clock.
module clk_div_multi_ch
    import clk_div_pkg::*;
#(
    parameter int DIV_RATIO_WIDTH = 8,
    parameter int NUM_CH          = 2
) (
    input  logic                              i_ref_clk,
    input  logic                              i_rst_n,
    input  logic [NUM_CH-1:0]                 i_div_en,
    input  logic [NUM_CH*DIV_RATIO_WIDTH-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]                 o_div_clk,
    output logic [NUM_CH-1:0]                 o_div_tick,
    output logic [NUM_CH*DIV_RATIO_WIDTH-1:0] o_ratio_act
);
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clk_div_core #(
            .W (DIV_RATIO_WIDTH)
        ) u_core (
            .ref_clk   (i_ref_clk),
            .rst_n     (i_rst_n),
            .div_en    (i_div_en[k]),
            .div_ratio (i_div_ratio[k*DIV_RATIO_WIDTH +: DIV_RATIO_WIDTH]),
            .div_clk   (o_div_clk[k]),
            .div_tick  (o_div_tick[k]),
            .ratio_act (o_ratio_act[k*DIV_RATIO_WIDTH +: DIV_RATIO_WIDTH])
        );
    end
endmodule

// File: tb/tb_clk_div_multi_ch.sv
// Directed bench for clk_div_multi_ch with hand-computed waveform vectors.
module tb_clk_div_multi_ch;
    localparam int W   = 8;
    localparam int NCH = 2;

    logic               ref_clk = 1'b0;
    logic               rst_n   = 1'b0;
    logic [NCH-1:0]     div_en  = '0;
    logic [NCH*W-1:0]   div_ratio = '0;
    logic [NCH-1:0]     div_clk;
    logic [NCH-1:0]     div_tick;
    logic [NCH*W-1:0]   ratio_act;

    int n_chk = 0;
    int n_err = 0;

    clk_div_multi_ch #(
        .DIV_RATIO_WIDTH (W),
        .NUM_CH          (NCH)
    ) dut (
        .i_ref_clk   (ref_clk),
        .i_rst_n     (rst_n),
        .i_div_en    (div_en),
        .i_div_ratio (div_ratio),
        .o_div_clk   (div_clk),
        .o_div_tick  (div_tick),
        .o_ratio_act (ratio_act)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge ref_clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Bit i of each vector holds the output seen just after the (i+1)-th posedge.
    task automatic capture(input int n, output logic [31:0] c0, output logic [31:0] t0,
                           output logic [31:0] c1, output logic [31:0] t1);
        c0 = '0; t0 = '0; c1 = '0; t1 = '0;
        for (int i = 0; i < n; i++) begin
            step();
            c0[i] = div_clk[0];
            t0[i] = div_tick[0];
            c1[i] = div_clk[1];
            t1[i] = div_tick[1];
        end
    endtask

    initial begin
        logic [31:0] c0, t0, c1, t1;
        logic [31:0] pn, tv;
        int hi, lo;

        // Reset dominates even with both channels enabled.
        div_en    = 2'b11;
        div_ratio = {8'd4, 8'd4};
        repeat (2) @(posedge ref_clk);
        #1;
        chk("rst_clk",   div_clk,   0);
        chk("rst_tick",  div_tick,  0);
        chk("rst_ratio", ratio_act, 0);

        // ch0 divide-by-4, ch1 disabled
        div_en = 2'b01;
        rst_n  = 1'b1;
        capture(8, c0, t0, c1, t1);
        chk("r4_clk",   c0, 32'b00110011);
        chk("r4_tick",  t0, 32'b00010001);
        chk("dis_clk",  c1, 0);
        chk("dis_tick", t1, 0);
        chk("r4_ract",  ratio_act[7:0], 4);

        // ch0 ratio 5 alongside ch1 ratio 2
        div_en    = 2'b11;
        div_ratio = {8'd2, 8'd5};
        do_reset();
        capture(10, c0, t0, c1, t1);
        chk("r5_clk",  c0, 32'b0001100011);
        chk("r5_tick", t0, 32'b0000100001);
        chk("r2_clk",  c1, 32'b0101010101);
        chk("r2_tick", t1, 32'b0101010101);

        // ratio 6 -> 3 mid high phase: change lands at the period boundary
        div_en    = 2'b01;
        div_ratio = {8'd0, 8'd6};
        do_reset();
        step();
        chk("r6_start_clk", div_clk[0], 1);
        chk("r6_ract",      ratio_act[7:0], 6);
        div_ratio[7:0] = 8'd3;
        capture(5, c0, t0, c1, t1);
        chk("r6_tail_clk",  c0, 32'b00011);
        chk("r6_tail_tick", t0, 0);
        chk("r6_ract_hold", ratio_act[7:0], 6);
        capture(5, c0, t0, c1, t1);
        chk("r3_clk",  c0, 32'b01001);
        chk("r3_tick", t0, 32'b01001);
        chk("r3_ract", ratio_act[7:0], 3);

        // Graceful stop: enable dropped in the first high cycle
        div_ratio = {8'd0, 8'd4};
        do_reset();
        step();
        div_en = 2'b00;
        capture(8, c0, t0, c1, t1);
        chk("stop_clk",  c0, 32'b00000001);
        chk("stop_tick", t0, 0);

        // Bypass, then hitless switch to divide-by-4
        div_en    = 2'b01;
        div_ratio = {8'd0, 8'd1};
        do_reset();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("byp_hi",   div_clk[0], 1);
            chk("byp_tick", div_tick[0], 0);
            @(negedge ref_clk);
            #1;
            chk("byp_lo", div_clk[0], 0);
            step();
        end
        div_ratio[7:0] = 8'd4;
        pn = '0;
        tv = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            pn[2*i] = div_clk[0];
            tv[i]   = div_tick[0];
            @(negedge ref_clk);
            #1;
            pn[2*i+1] = div_clk[0];
        end
        chk("byp_exit_clk",  pn, 32'b0000111100001111);
        chk("byp_exit_tick", tv, 32'b00010001);

        // ratio 255: 127/128 split, then async reset mid low phase
        div_en    = 2'b11;
        div_ratio = {8'd3, 8'd255};
        do_reset();
        step();
        chk("r255_tick0", div_tick[0], 1);
        hi = 0;
        while (div_clk[0] && hi < 300) begin
            hi++;
            step();
        end
        chk("r255_high", hi, 127);
        lo = 0;
        while (!div_clk[0] && lo < 300) begin
            lo++;
            step();
        end
        chk("r255_low",   lo, 128);
        chk("r255_tick1", div_tick[0], 1);
        repeat (127 + 50) step();
        chk("r255_midlow_clk", div_clk[0], 0);
        chk("r255_ract",       ratio_act[7:0], 255);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_clk",   div_clk,   0);
        chk("arst_tick",  div_tick,  0);
        chk("arst_ratio", ratio_act, 0);
        step();
        rst_n = 1'b1;
        capture(2, c0, t0, c1, t1);
        chk("restart_clk",   c0, 32'b11);
        chk("restart_tick",  t0, 32'b01);
        chk("restart_ract",  ratio_act[7:0], 255);
        chk("restart_ch1",   c1, 32'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
